// File: rtl/l2_tag_lookup.sv
// Set-associative L2 tag lookup: IDLE -> LOOKUP -> RESPOND per request.
// Holds valid/dirty/true-LRU state per set and counts hits and misses.
module l2_tag_lookup #(
   parameter int tagBits   = 12,
   parameter int indexBits = 14,
   parameter int ways      = 8,
   parameter int wayBits   = 3,
   parameter int countBits = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 reqValid,
   output logic                 reqReady,
   input  logic [tagBits-1:0]   reqTag,
   input  logic [indexBits-1:0] reqIndex,
   input  logic                 reqWrite,
   output logic                 respValid,
   output logic                 respHit,
   output logic [wayBits-1:0]   respWay,
   output logic                 respEvict,
   output logic [tagBits-1:0]   respEvictTag,
   output logic                 respEvictDirty,
   output logic [countBits-1:0] hitCount,
   output logic [countBits-1:0] missCount
);

   localparam int sets = 1 << indexBits;

   typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND} state_t;

   state_t r_state, w_next;
   logic   w_accept;
   logic   r_ready;

   logic [tagBits-1:0]   r_tag;
   logic [indexBits-1:0] r_index;
   logic                 r_write;

   logic [ways-1:0]    r_valid [sets];
   logic [ways-1:0]    r_dirty [sets];
   logic [tagBits-1:0] r_tags  [sets][ways];
   logic [wayBits-1:0] r_age   [sets][ways];

   logic               w_hit, w_hasInv;
   logic [wayBits-1:0] w_hitWay, w_invWay, w_lruWay, w_way;

   logic               r_hit, r_oldValid, r_oldDirty;
   logic [wayBits-1:0] r_way, r_oldAge;
   logic [tagBits-1:0] r_oldTag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         IDLE: begin
            if (reqValid && r_ready) begin
               w_accept = 1'b1;
               w_next   = LOOKUP;
            end
         end
         LOOKUP:  w_next = RESPOND;
         RESPOND: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Registered ready keeps reqReady low throughout reset and only rises in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ready <= 1'b0;
      else        r_ready <= (w_next == IDLE);
   end

   assign reqReady = r_ready;

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tag   <= reqTag;
         r_index <= reqIndex;
         r_write <= reqWrite;
      end
   end

   // Descending scan so the lowest-indexed match / invalid way wins.
   always_comb begin
      w_hit    = 1'b0;
      w_hasInv = 1'b0;
      w_hitWay = '0;
      w_invWay = '0;
      w_lruWay = '0;
      for (int w = ways - 1; w >= 0; w--) begin
         if (r_valid[r_index][w] && (r_tags[r_index][w] == r_tag)) begin
            w_hit    = 1'b1;
            w_hitWay = wayBits'(w);
         end
         if (!r_valid[r_index][w]) begin
            w_hasInv = 1'b1;
            w_invWay = wayBits'(w);
         end
         if (r_age[r_index][w] == wayBits'(ways - 1)) w_lruWay = wayBits'(w);
      end
      w_way = w_hit ? w_hitWay : (w_hasInv ? w_invWay : w_lruWay);
   end

   always_ff @(posedge clk) begin
      if (r_state == LOOKUP) begin
         r_hit      <= w_hit;
         r_way      <= w_way;
         r_oldValid <= r_valid[r_index][w_way];
         r_oldDirty <= r_dirty[r_index][w_way];
         r_oldTag   <= r_tags[r_index][w_way];
         r_oldAge   <= r_age[r_index][w_way];
      end
   end

   always_ff @(posedge clk) begin
      if ((r_state == RESPOND) && !r_hit) r_tags[r_index][r_way] <= r_tag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < sets; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            for (int w = 0; w < ways; w++) r_age[s][w] <= wayBits'(w);
         end
         respValid      <= 1'b0;
         respHit        <= 1'b0;
         respWay        <= '0;
         respEvict      <= 1'b0;
         respEvictTag   <= '0;
         respEvictDirty <= 1'b0;
         hitCount       <= '0;
         missCount      <= '0;
      end else begin
         respValid <= 1'b0;
         if (r_state == RESPOND) begin
            respValid      <= 1'b1;
            respHit        <= r_hit;
            respWay        <= r_way;
            respEvict      <= !r_hit && r_oldValid;
            respEvictTag   <= (!r_hit && r_oldValid) ? r_oldTag : '0;
            respEvictDirty <= !r_hit && r_oldValid && r_oldDirty;
            if (r_hit) begin
               r_dirty[r_index][r_way] <= r_dirty[r_index][r_way] | r_write;
               hitCount                <= hitCount + countBits'(1);
            end else begin
               r_valid[r_index][r_way] <= 1'b1;
               r_dirty[r_index][r_way] <= r_write;
               missCount               <= missCount + countBits'(1);
            end
            // Younger-than-accessed ways age by one; accessed way becomes MRU.
            for (int w = 0; w < ways; w++) begin
               if (wayBits'(w) == r_way)            r_age[r_index][w] <= '0;
               else if (r_age[r_index][w] < r_oldAge) r_age[r_index][w] <= r_age[r_index][w] + wayBits'(1);
            end
         end
      end
   end

endmodule

// File: doc/l2_tag_lookup.md
Name: l2_tag_lookup

Overview:
Downstream stage of the address dissector. It consumes the dissected tag/index plus a read/write flag and looks up a set-associative L2 tag store. It returns hit/miss, the hit or allocated way, and the eviction information the data/bus stage needs. It owns valid, dirty and true-LRU state for every set and keeps hit/miss statistics.

Parameters:
tagBits, 12, width of address tag
indexBits, 14, width of set index (2^indexBits sets)
ways, 8, associativity (power of two, >=2)
wayBits, 3, log2(ways)
countBits, 32, width of hit/miss statistic counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
reqValid  input  1  request present
reqReady  output  1  block can accept request this cycle
reqTag  input  tagBits  tag from address dissector
reqIndex  input  indexBits  set index from address dissector
reqWrite  input  1  1 = write access, 0 = read
respValid  output  1  one-cycle pulse; response fields valid
respHit  output  1  1 = tag found in a valid way
respWay  output  wayBits  way hit, or way allocated on miss
respEvict  output  1  miss replaced a valid line
respEvictTag  output  tagBits  tag of replaced line
respEvictDirty  output  1  replaced line was dirty
hitCount  output  countBits  total hits since reset
missCount  output  countBits  total misses since reset

Behaviour:
- Reset (async, rst_n low): FSM to IDLE; all valid and dirty bits 0; LRU age of way w in every set = w; all resp* outputs 0; counters 0; reqReady 0 while in reset, 1 in IDLE after release.
- FSM states: IDLE -> LOOKUP -> RESPOND -> IDLE. No other transitions.
- IDLE: reqReady=1. Accept when reqValid && reqReady. Latch tag, index and write into request registers. Go to LOOKUP.
- LOOKUP: reqReady=0. Read the latched set's tags, valid, dirty and ages. Compare all ways in parallel. Hit = exactly one valid way with matching tag. If several match, the lowest way index wins; this condition is an assertion failure in the bench.
- Miss victim: choose the lowest-indexed invalid way. If all ways are valid, choose the way whose age == ways-1. Go to RESPOND.
- RESPOND: register the response and drive respValid=1 for exactly this cycle. Response latency is therefore accept edge N -> respValid high in cycle N+2. Back-to-back throughput is one request per 3 cycles.
- State updates in RESPOND:
  - Hit: dirty[way] |= reqWrite. Tag and valid unchanged. hitCount+1.
  - Miss: tag[victim] = reqTag, valid=1, dirty = reqWrite. respEvict = old valid of the victim; respEvictTag and respEvictDirty carry its old contents (0 when respEvict=0). missCount+1.
- LRU update on each access to way w whose old age is a: every way in the set with age < a increments, and w is set to 0. Ages stay a permutation of 0..ways-1 at all times.
- reqValid outside IDLE is ignored. It is neither captured nor queued, and the requester must hold it until reqReady.
- resp fields other than respValid hold their last value after the pulse.
- Counters wrap modulo 2^countBits with no saturation.
- Reset mid-LOOKUP or mid-RESPOND: the request is dropped, no respValid is produced, and all state returns to reset values.
- Accesses to different sets never alter each other's valid, dirty or LRU state.

Test Plan:
1. Reset, then read tag 0x0AB at index 0x0010 -> respValid at N+2: hit=0, way=0, evict=0, missCount=1. Repeat the same request -> hit=1, way=0, hitCount=1.
2. Reads of tags 0x001..0x008 to index 5 -> ways 0..7, all misses, evict=0. Then read tag 0x009 -> way 0, evict=1, evictTag=0x001, evictDirty=0.
3. Same fill as scenario 2, but re-read tag 0x001 before tag 0x009 -> that is a hit in way 0. Tag 0x009 then allocates way 1 with evictTag=0x002.
4. Write tag 0x0AB at index 3 (miss, way 0), then read 8 new tags at index 3 -> the 8th new tag evicts way 0 with evictTag=0x0AB and evictDirty=1.
5. Hold reqValid continuously with alternating tags -> an accept occurs only every 3rd cycle, reqReady=0 in LOOKUP/RESPOND, and no request is lost or duplicated.
6. Pull rst_n low during LOOKUP -> no respValid. After release, the previously filled index misses at way 0 and both counters read 0.
